ocp_axil_arb: RTL and testbench

OCP_AXIL_ARB -- requirements
Module: ocp_axil_arb

---
 rtl/ocp_axil_arb.sv | 153 +++++++++++++++
 tb/tb_ocp_axil_arb.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ocp_axil_arb.sv
// ocp_axil_arb: two-requester OCP to AXI4-Lite master bridge, round-robin arbitrated,
// one command outstanding at a time.
module ocp_axil_arb #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [5:0]          m_cmd,
   input  logic [2*ADDR_W-1:0] m_addr,
   input  logic [2*DATA_W-1:0] m_data,
   output logic [1:0]          s_cmdaccept,
   output logic [3:0]          s_resp,
   output logic [DATA_W-1:0]   s_data,
   output logic                awvalid,
   input  logic                awready,
   output logic [ADDR_W-1:0]   awaddr,
   output logic                wvalid,
   input  logic                wready,
   output logic [DATA_W-1:0]   wdata,
   output logic [DATA_W/8-1:0] wstrb,
   input  logic                bvalid,
   output logic                bready,
   input  logic [1:0]          bresp,
   output logic                arvalid,
   input  logic                arready,
   output logic [ADDR_W-1:0]   araddr,
   input  logic                rvalid,
   output logic                rready,
   input  logic [DATA_W-1:0]   rdata,
   input  logic [1:0]          rresp
);
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] WR_REQ  = 3'd1;
   localparam logic [2:0] WR_RESP = 3'd2;
   localparam logic [2:0] RD_REQ  = 3'd3;
   localparam logic [2:0] RD_DATA = 3'd4;
   localparam logic [2:0] RESP    = 3'd5;
   logic [2:0]        state_q, state_d;
   logic [1:0]        acc_q, acc_d;
   logic              gnt_q, gnt_d, last_q, last_d, wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d, rdat_q, rdat_d;
   logic              awv_q, awv_d, wv_q, wv_d, arv_q, arv_d, bry_q, bry_d, rry_q, rry_d;
   logic [3:0]        sresp_q, sresp_d;
   logic [1:0]        req, code;
   logic [2:0]        cmd_sel;
   logic              sel, arb;
   assign req[0]  = m_cmd[2:0] == 3'd1 || m_cmd[2:0] == 3'd2;
   assign req[1]  = m_cmd[5:3] == 3'd1 || m_cmd[5:3] == 3'd2;
   assign sel     = &req ? ~last_q : req[1];
   assign cmd_sel = sel ? m_cmd[5:3] : m_cmd[2:0];
   // Grant from a quiet IDLE, or from RESP so the next accept lands the cycle after the response.
   assign arb     = |req && ((state_q == IDLE && acc_q == 2'b00) || state_q == RESP);
   assign code    = ((state_q == WR_RESP ? bresp : rresp) == 2'b00) ? 2'b01 : 2'b11;
   always_comb begin
      state_d = state_q;
      acc_d   = 2'b00;
      gnt_d   = gnt_q;
      last_d  = last_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      data_d  = data_q;
      rdat_d  = rdat_q;
      awv_d   = awv_q && !awready;
      wv_d    = wv_q && !wready;
      arv_d   = arv_q && !arready;
      bry_d   = bry_q;
      rry_d   = rry_q;
      sresp_d = 4'd0;
      if (arb) begin
         acc_d  = sel ? 2'b10 : 2'b01;
         gnt_d  = sel;
         last_d = sel;
         wr_d   = cmd_sel == 3'd1;
         addr_d = sel ? m_addr[ADDR_W +: ADDR_W] : m_addr[0 +: ADDR_W];
         data_d = sel ? m_data[DATA_W +: DATA_W] : m_data[0 +: DATA_W];
      end
      case (state_q)
         IDLE: if (acc_q != 2'b00) begin
            state_d = wr_q ? WR_REQ : RD_REQ;
            awv_d   = wr_q;
            wv_d    = wr_q;
            arv_d   = !wr_q;
         end
         WR_REQ: if (!awv_d && !wv_d) begin
            state_d = WR_RESP;
            bry_d   = 1'b1;
         end
         WR_RESP: if (bvalid) begin
            state_d = RESP;
            bry_d   = 1'b0;
            sresp_d = gnt_q ? {code, 2'b00} : {2'b00, code};
         end
         RD_REQ: if (!arv_d) begin
            state_d = RD_DATA;
            rry_d   = 1'b1;
         end
         RD_DATA: if (rvalid) begin
            state_d = RESP;
            rry_d   = 1'b0;
            rdat_d  = rdata;
            sresp_d = gnt_q ? {code, 2'b00} : {2'b00, code};
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= 2'b00;
         gnt_q   <= 1'b0;
         last_q  <= 1'b1;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         rdat_q  <= '0;
         awv_q   <= 1'b0;
         wv_q    <= 1'b0;
         arv_q   <= 1'b0;
         bry_q   <= 1'b0;
         rry_q   <= 1'b0;
         sresp_q <= 4'd0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         rdat_q  <= rdat_d;
         awv_q   <= awv_d;
         wv_q    <= wv_d;
         arv_q   <= arv_d;
         bry_q   <= bry_d;
         rry_q   <= rry_d;
         sresp_q <= sresp_d;
      end
   end
   assign s_cmdaccept = acc_q;
   assign s_resp      = sresp_q;
   assign s_data      = rdat_q;
   assign awvalid     = awv_q;
   assign awaddr      = addr_q;
   assign wvalid      = wv_q;
   assign wdata       = data_q;
   assign wstrb       = '1;
   assign bready      = bry_q;
   assign arvalid     = arv_q;
   assign araddr      = addr_q;
   assign rready      = rry_q;
endmodule

// File: tb/tb_ocp_axil_arb.sv
// tb_ocp_axil_arb: directed vectors for ocp_axil_arb, outputs sampled on the falling edge.
module tb_ocp_axil_arb;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  m_cmd = '0;
   logic [63:0] m_addr = '0;
   logic [63:0] m_data = '0;
   logic [1:0]  s_cmdaccept;
   logic [3:0]  s_resp;
   logic [31:0] s_data;
   logic        awvalid, awready = 1'b0;
   logic [31:0] awaddr;
   logic        wvalid, wready = 1'b0;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        bvalid = 1'b0, bready;
   logic [1:0]  bresp = 2'b00;
   logic        arvalid, arready = 1'b0;
   logic [31:0] araddr;
   logic        rvalid = 1'b0, rready;
   logic [31:0] rdata = '0;
   logic [1:0]  rresp = 2'b00;
   int          n_vec = 0;
   int          n_err = 0;
   ocp_axil_arb dut (
      .clk(clk), .rst(rst), .m_cmd(m_cmd), .m_addr(m_addr), .m_data(m_data),
      .s_cmdaccept(s_cmdaccept), .s_resp(s_resp), .s_data(s_data),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(negedge clk);
   endtask
   task automatic rd_txn(input int g, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] rr, input logic [3:0] er);
      step();
      chk("rd_accept", s_cmdaccept, 64'd1 << g);
      step();
      chk("arvalid", arvalid, 1);
      chk("araddr", araddr, a);
      step();
      chk("rready", rready, 1);
      chk("arvalid_drop", arvalid, 0);
      rvalid = 1'b1;
      rdata  = d;
      rresp  = rr;
      step();
      chk("rd_sresp", s_resp, er);
      chk("s_data", s_data, d);
      chk("rready_drop", rready, 0);
      rvalid = 1'b0;
   endtask
   task automatic wr_txn(input int g, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] br, input logic [3:0] er);
      step();
      chk("wr_accept", s_cmdaccept, 64'd1 << g);
      m_cmd = '0;
      step();
      chk("awvalid", awvalid, 1);
      chk("wvalid", wvalid, 1);
      chk("awaddr", awaddr, a);
      chk("wdata", wdata, d);
      chk("wstrb", wstrb, 4'hF);
      chk("accept_low", s_cmdaccept, 0);
      step();
      chk("bready", bready, 1);
      chk("awvalid_drop", awvalid, 0);
      chk("wvalid_drop", wvalid, 0);
      bvalid = 1'b1;
      bresp  = br;
      step();
      chk("wr_sresp", s_resp, er);
      chk("bready_drop", bready, 0);
      bvalid = 1'b0;
   endtask
   initial begin
      step();
      chk("rst_accept", s_cmdaccept, 0);
      chk("rst_sresp", s_resp, 0);
      chk("rst_sdata", s_data, 0);
      chk("rst_awvalid", awvalid, 0);
      chk("rst_arvalid", arvalid, 0);
      chk("rst_bready", bready, 0);
      rst = 1'b0;
      // single write from requester 0
      m_cmd   = 6'b000_001;
      m_addr  = {32'h0, 32'h1000};
      m_data  = {32'h0, 32'hDEADBEEF};
      awready = 1'b1;
      wready  = 1'b1;
      wr_txn(0, 32'h1000, 32'hDEADBEEF, 2'b00, 4'b0001);
      step();
      chk("wr_resp_one_cycle", s_resp, 0);
      chk("idle_no_accept", s_cmdaccept, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      // both requesters reading continuously: grants alternate starting with 0
      m_cmd   = 6'b010_010;
      m_addr  = {32'h3000, 32'h2000};
      arready = 1'b1;
      rd_txn(0, 32'h2000, 32'h11111111, 2'b00, 4'b0001);
      rd_txn(1, 32'h3000, 32'h22222222, 2'b00, 4'b0100);
      rd_txn(0, 32'h2000, 32'h33333333, 2'b00, 4'b0001);
      rd_txn(1, 32'h3000, 32'h44444444, 2'b00, 4'b0100);
      m_cmd = '0;
      step();
      chk("rd_resp_one_cycle", s_resp, 0);
      // reserved commands are idle, stray responses ignored
      m_cmd  = 6'b111_011;
      bvalid = 1'b1;
      rvalid = 1'b1;
      step();
      chk("reserved_no_accept", s_cmdaccept, 0);
      chk("stray_bready", bready, 0);
      chk("stray_rready", rready, 0);
      chk("stray_sresp", s_resp, 0);
      bvalid = 1'b0;
      rvalid = 1'b0;
      // requester 1 alone wins even though it was granted last; SLVERR -> ERR
      m_cmd  = 6'b010_000;
      m_addr = {32'h5000, 32'h0};
      rd_txn(1, 32'h5000, 32'hCAFEF00D, 2'b10, 4'b1100);
      m_cmd = '0;
      step();
      chk("err_one_cycle", s_resp, 0);
      // split handshake: AW at N+1, W held off until N+4
      m_cmd  = 6'b000_001;
      m_addr = {32'h0, 32'h6000};
      m_data = {32'h0, 32'hA5A5A5A5};
      wready = 1'b0;
      step();
      chk("split_accept", s_cmdaccept, 2'b01);
      m_cmd = '0;
      step();
      chk("split_aw_n1", awvalid, 1);
      chk("split_w_n1", wvalid, 1);
      step();
      chk("split_aw_n2", awvalid, 0);
      chk("split_w_n2", wvalid, 1);
      chk("split_bready_n2", bready, 0);
      step();
      chk("split_w_n3", wvalid, 1);
      chk("split_wdata_n3", wdata, 32'hA5A5A5A5);
      step();
      chk("split_w_n4", wvalid, 1);
      chk("split_bready_n4", bready, 0);
      wready = 1'b1;
      step();
      chk("split_w_n5", wvalid, 0);
      chk("split_bready_n5", bready, 1);
      bvalid = 1'b1;
      step();
      chk("split_sresp", s_resp, 4'b0001);
      bvalid = 1'b0;
      // reset while waiting for B abandons the write
      m_cmd  = 6'b000_001;
      m_addr = {32'h0, 32'h4000};
      m_data = {32'h0, 32'h12345678};
      step();
      chk("abort_accept", s_cmdaccept, 2'b01);
      m_cmd = '0;
      step();
      chk("abort_awvalid", awvalid, 1);
      step();
      chk("abort_in_wr_resp", bready, 1);
      rst = 1'b1;
      #1;
      chk("async_bready", bready, 0);
      chk("async_awaddr", awaddr, 0);
      chk("async_wdata", wdata, 0);
      chk("async_sdata", s_data, 0);
      chk("async_sresp", s_resp, 0);
      chk("async_accept", s_cmdaccept, 0);
      step();
      rst   = 1'b0;
      m_cmd = 6'b010_010;
      step();
      chk("post_rst_grant0", s_cmdaccept, 2'b01);
      chk("post_rst_no_resp", s_resp, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
